mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates an instruction-fetch port and a data port onto one shared single-port memory bus.
// Latency: request sampled at edge N, bus_req_o high in cycle N+1, x_ack_o in the cycle after bus_ack_i (min 2 cycles).
// Backpressure: requesters hold x_req_i until x_ack_o; stallreq_o stalls the pipeline meanwhile; a stuck bus aborts after TIMEOUT cycles.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   if_req_i/if_addr_i     fetch read request, if_rdata_o/if_ack_o completion
//   mem_req_i/we/sel/addr/wdata   data request, mem_rdata_o/mem_ack_o completion
//   bus_req_o/we/sel/addr/wdata   shared memory request, bus_rdata_i/bus_ack_i completion
//   stallreq_o             pipeline stall request; err_o one-cycle timeout pulse
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ack_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [3:0]        mem_sel_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_ack_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [3:0]        bus_sel_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_ack_i,
   output logic              stallreq_o,
   output logic              err_o
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

   // The abort fires at the edge that ends the TIMEOUT-th BUSY cycle without an ack,
   // i.e. when the counter already holds TIMEOUT-1.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic              last_mem;      // 1 = last acked grant went to MEM, 0 = IF
   logic [7:0]        wait_cnt;
   logic              grant_if, grant_mem, done, abort;
   logic              lat_we;
   logic [3:0]        lat_sel;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            // On a tie the requester that did not win last time gets the bus.
            if (if_req_i && (!mem_req_i || last_mem)) begin
               state_nxt = BUSY_IF;
               grant_if  = 1'b1;
            end else if (mem_req_i) begin
               state_nxt = BUSY_MEM;
               grant_mem = 1'b1;
            end
         end
         BUSY_IF, BUSY_MEM: begin
            // Ack is tested first so it wins against a coincident timeout.
            if (bus_ack_i) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_mem    <= 1'b0;
         wait_cnt    <= '0;
         lat_we      <= 1'b0;
         lat_sel     <= '0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         if_rdata_o  <= '0;
         if_ack_o    <= 1'b0;
         mem_rdata_o <= '0;
         mem_ack_o   <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         if_ack_o  <= 1'b0;
         mem_ack_o <= 1'b0;
         err_o     <= 1'b0;
         if (grant_if) begin
            lat_we    <= 1'b0;
            lat_sel   <= 4'hF;
            lat_addr  <= if_addr_i;
            lat_wdata <= '0;
            wait_cnt  <= '0;
         end else if (grant_mem) begin
            lat_we    <= mem_we_i;
            lat_sel   <= mem_sel_i;
            lat_addr  <= mem_addr_i;
            lat_wdata <= mem_wdata_i;
            wait_cnt  <= '0;
         end else if (state != IDLE && !bus_ack_i) begin
            wait_cnt  <= wait_cnt + 8'd1;
         end
         if (done || abort) begin
            if (state == BUSY_IF) begin
               if_rdata_o <= done ? bus_rdata_i : '0;
               if_ack_o   <= 1'b1;
            end else begin
               mem_rdata_o <= done ? bus_rdata_i : '0;
               mem_ack_o   <= 1'b1;
            end
            err_o <= abort;
         end
         // Only a real completion moves the fairness pointer.
         if (done) last_mem <= (state == BUSY_MEM);
      end
   end

   // Driven from the latches only so requesters may change inputs once granted.
   assign bus_req_o   = (state != IDLE);
   assign bus_we_o    = lat_we;
   assign bus_sel_o   = lat_sel;
   assign bus_addr_o  = lat_addr;
   assign bus_wdata_o = lat_wdata;

   assign stallreq_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

endmodule
